// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if
// Bundles the request/response handshake of the system-bus memory responder.
//   reqcyc  : initiator request / write-data valid
//   req     : request address (request cycle) or write data (write-data cycle)
//   reqtag  : request tag, MSB = 1 for READ, 0 for WRITE
//   reqack  : responder accepts an address or a write-data beat
//   respcyc : read-response beat valid
//   resp    : read-response data
//   resptag : tag of the request being answered
//   respack : initiator accepts the current response beat
// Modports: master (initiator side), slave (responder side).
interface sysbus_mem_responder_if #(
    parameter int TAG_W = 13
);
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
// Single-outstanding-transaction memory responder for 64-byte line transfers.
// A request names a line (req[63:6]); reads return 8 beats of 64-bit data
// after a fixed latency, writes take 8 data beats from the initiator.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : sysbus_mem_responder_if.slave (request/response handshake)
// Parameters:
//   LATENCY   : cycles from the address accept pulse to the first read beat
//               (1..15; the ACK->WAIT->RESP path needs at least 2 cycles,
//               so LATENCY=1 behaves like LATENCY=2)
//   MEM_LINES : backing-store depth in 64-byte lines (>= 2)
//   TAG_W     : tag width
module sysbus_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 1024,
    parameter int TAG_W     = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    sysbus_mem_responder_if.slave bus
);

    localparam int          LINE_AW  = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int          WORD_AW  = LINE_AW + 3;
    localparam int          WORDS    = MEM_LINES * 8;
    localparam logic [57:0] LINES_W  = 58'(MEM_LINES);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        WDATA = 3'd4
    } state_t;

    state_t           state_r;
    logic             ack_r;
    logic             respcyc_r;
    logic [63:0]      resp_r;
    logic [TAG_W-1:0] tag_r;
    logic [2:0]       beat_r;
    logic [3:0]       cnt_r;
    logic [57:0]      line_r;

    // Backing store; deliberately outside the reset domain.
    logic [63:0]      mem_r [WORDS];

    logic               in_range_s;
    logic               wr_take_s;
    logic [2:0]         rd_beat_s;
    logic [WORD_AW-1:0] rd_addr_s;
    logic [WORD_AW-1:0] wr_addr_s;
    logic [63:0]        rd_word_s;

    // Address decode: range check, write strobe and the word to present next.
    always_comb begin
        in_range_s = (line_r < LINES_W);
        wr_take_s  = 1'b0;
        rd_beat_s  = 3'd0;
        // In WAIT the next word is beat 0; in RESP it is the beat after the
        // one currently on resp, so resp_r can be reloaded on acceptance.
        if (state_r == RESP) begin
            rd_beat_s = beat_r + 3'd1;
        end else begin
            rd_beat_s = 3'd0;
        end
        if (state_r == WDATA) begin
            wr_take_s = bus.reqcyc;
        end else begin
            wr_take_s = 1'b0;
        end
        rd_addr_s = {line_r[LINE_AW-1:0], rd_beat_s};
        wr_addr_s = {line_r[LINE_AW-1:0], beat_r};
        // Out-of-range lines read as zero and never index the array.
        if (in_range_s) begin
            rd_word_s = mem_r[rd_addr_s];
        end else begin
            rd_word_s = 64'd0;
        end
    end

    // Backing-store write port; out-of-range writes are acked but dropped.
    always_ff @(posedge clk) begin
        if (wr_take_s && in_range_s) begin
            mem_r[wr_addr_s] <= bus.req;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            ack_r     <= 1'b0;
            respcyc_r <= 1'b0;
            resp_r    <= 64'd0;
            tag_r     <= '0;
            beat_r    <= 3'd0;
            cnt_r     <= 4'd0;
            line_r    <= 58'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    respcyc_r <= 1'b0;
                    beat_r    <= 3'd0;
                    if (bus.reqcyc) begin
                        line_r  <= bus.req[63:6];
                        tag_r   <= bus.reqtag;
                        ack_r   <= 1'b1;
                        state_r <= ACK;
                    end else begin
                        ack_r   <= 1'b0;
                    end
                end
                ACK: begin
                    ack_r  <= 1'b0;
                    beat_r <= 3'd0;
                    if (tag_r[TAG_W-1]) begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= WAIT;
                    end else begin
                        state_r <= WDATA;
                    end
                end
                WAIT: begin
                    // Leave on the edge where the count reaches zero so the
                    // first beat appears LATENCY cycles after the ack pulse.
                    if (cnt_r <= 4'd1) begin
                        cnt_r     <= 4'd0;
                        beat_r    <= 3'd0;
                        resp_r    <= rd_word_s;
                        respcyc_r <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        cnt_r     <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.respack) begin
                        if (beat_r == 3'd7) begin
                            respcyc_r <= 1'b0;
                            beat_r    <= 3'd0;
                            state_r   <= IDLE;
                        end else begin
                            beat_r    <= beat_r + 3'd1;
                            resp_r    <= rd_word_s;
                        end
                    end
                end
                WDATA: begin
                    if (bus.reqcyc) begin
                        if (beat_r == 3'd7) begin
                            beat_r  <= 3'd0;
                            state_r <= IDLE;
                        end else begin
                            beat_r  <= beat_r + 3'd1;
                        end
                    end
                end
                default: begin
                    ack_r     <= 1'b0;
                    respcyc_r <= 1'b0;
                    beat_r    <= 3'd0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // The address ack is a registered pulse; a write-data ack is given in
    // the same cycle the beat is taken so the initiator can stream data.
    assign bus.reqack  = ack_r | wr_take_s;
    assign bus.respcyc = respcyc_r;
    assign bus.resp    = resp_r;
    assign bus.resptag = tag_r;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder
// Self-checking bench for sysbus_mem_responder. A line-addressed memory model
// (associative array of words) predicts read data; timing expectations come
// from the handshake rules (ack one cycle after request, first beat LATENCY
// cycles after the ack, acks only in IDLE/WDATA).
module tb_sysbus_mem_responder;

    localparam int LATENCY   = 4;
    localparam int MEM_LINES = 1024;
    localparam int TAG_W     = 13;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model [longint];

    sysbus_mem_responder_if #(.TAG_W(TAG_W)) bus ();

    sysbus_mem_responder #(
        .LATENCY   (LATENCY),
        .MEM_LINES (MEM_LINES),
        .TAG_W     (TAG_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model_rd(input longint line, input int b);
        if (line >= MEM_LINES) return 64'd0;
        if (model.exists(line * 8 + b)) return model[line * 8 + b];
        return 64'd0;
    endfunction

    // Present a request at the current negedge; expect the ack one cycle later.
    task automatic start_req(input logic [63:0] addr, input logic [TAG_W-1:0] tag, input bit hold);
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        @(negedge clk);
        n_checks++;
        if (bus.reqack !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_ack: reqack=%b required 1 (addr=%h)", bus.reqack, addr);
        end
        if (!hold) bus.reqcyc = 1'b0;
    endtask

    // Drive 8 write beats with an optional gap before gap_beat and optional
    // reset after abort_after beats.
    task automatic do_write(input logic [63:0] addr, input logic [TAG_W-1:0] tag,
                            input logic [63:0] d [8], input int gap_beat,
                            input int gap_len, input int abort_after);
        longint line;
        line = longint'(addr >> 6);
        start_req(addr, tag, 1'b0);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            if (b == abort_after) begin
                bus.reqcyc = 1'b0;
                reset = 1'b0;
                #1;
                n_checks++;
                if (bus.reqack !== 1'b0 || bus.respcyc !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_abort: reqack=%b respcyc=%b required 0 0", bus.reqack, bus.respcyc);
                end
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            if (b == gap_beat) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.reqcyc = 1'b0;
                    bus.req    = {$urandom, $urandom};
                    #1;
                    n_checks++;
                    if (bus.reqack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wr_gap_noack: beat=%0d reqack=%b required 0", b, bus.reqack);
                    end
                    @(negedge clk);
                end
            end
            bus.reqcyc = 1'b1;
            bus.req    = d[b];
            #1;
            n_checks++;
            if (bus.reqack !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_beat_ack: beat=%0d reqack=%b required 1", b, bus.reqack);
            end
            if (line < MEM_LINES) model[line * 8 + b] = d[b];
            @(negedge clk);
        end
        bus.reqcyc = 1'b0;
        #1;
        n_checks++;
        if (bus.reqack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_end_noack: reqack=%b required 0", bus.reqack);
        end
    endtask

    // Collect a read after its address ack: latency, 8 beats, stalls,
    // optional reqcyc noise, optional reset before abort_beat.
    task automatic finish_read(input longint line, input logic [TAG_W-1:0] tag,
                               input int stall_beat, input int stall_len,
                               input bit noise, input int abort_beat);
        int waited;
        logic [63:0] exp;
        waited = 0;
        bus.respack = 1'b0;
        while (bus.respcyc !== 1'b1 && waited < 40) begin
            if (noise) bus.reqcyc = 1'($urandom_range(0, 1));
            @(negedge clk);
            waited++;
            n_checks++;
            if (bus.reqack !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_noack: cycle=%0d reqack=%b required 0", waited, bus.reqack);
            end
        end
        n_checks++;
        if (waited !== LATENCY) begin
            n_fail++;
            $display("FAIL rd_latency: first beat after %0d cycles required %0d", waited, LATENCY);
        end
        if (bus.respcyc !== 1'b1) begin
            bus.reqcyc = 1'b0;
            return;
        end
        for (int b = 0; b < 8; b++) begin
            if (b == abort_beat) begin
                bus.reqcyc = 1'b0;
                reset = 1'b0;
                #1;
                n_checks++;
                if (bus.respcyc !== 1'b0 || bus.resp !== 64'd0 || bus.resptag !== '0) begin
                    n_fail++;
                    $display("FAIL rd_abort: respcyc=%b resp=%h resptag=%h required 0 0 0",
                             bus.respcyc, bus.resp, bus.resptag);
                end
                @(negedge clk);
                reset = 1'b1;
                bus.respack = 1'b0;
                @(negedge clk);
                n_checks++;
                if (bus.respcyc !== 1'b0 || bus.reqack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_after_abort: respcyc=%b reqack=%b required 0 0", bus.respcyc, bus.reqack);
                end
                return;
            end
            exp = model_rd(line, b);
            n_checks++;
            if (bus.respcyc !== 1'b1 || bus.resp !== exp || bus.resptag !== tag) begin
                n_fail++;
                $display("FAIL rd_beat: line=%0h beat=%0d respcyc=%b resp=%h tag=%h required 1 %h %h",
                         line, b, bus.respcyc, bus.resp, bus.resptag, exp, tag);
            end
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.respack = 1'b0;
                    if (noise) bus.reqcyc = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n_checks++;
                    if (bus.respcyc !== 1'b1 || bus.resp !== exp || bus.reqack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rd_stall: beat=%0d respcyc=%b resp=%h reqack=%b required 1 %h 0",
                                 b, bus.respcyc, bus.resp, bus.reqack, exp);
                    end
                end
            end
            bus.respack = 1'b1;
            if (noise) bus.reqcyc = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (bus.reqack !== 1'b0) begin
                n_fail++;
                $display("FAIL resp_noack: beat=%0d reqack=%b required 0", b, bus.reqack);
            end
        end
        bus.respack = 1'b0;
        if (noise) bus.reqcyc = 1'b0;
        n_checks++;
        if (bus.respcyc !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_end: respcyc=%b required 0 after beat 7", bus.respcyc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.reqack !== 1'b0 || bus.respcyc !== 1'b0 || bus.resp !== 64'd0 || bus.resptag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: reqack=%b respcyc=%b resp=%h resptag=%h required 0 0 0 0",
                     bus.reqack, bus.respcyc, bus.resp, bus.resptag);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.reqack !== 1'b0 || bus.respcyc !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: reqack=%b respcyc=%b required 0 0", bus.reqack, bus.respcyc);
        end
    endtask

    task automatic test_read_basic();
        logic [63:0] d [8];
        for (int k = 0; k < 8; k++) d[k] = 64'h100 + 64'(k);
        do_write(64'h1040, 13'h0000, d, -1, 0, -1);
        start_req(64'h1040, 13'h1000, 1'b0);
        finish_read(64'h41, 13'h1000, -1, 0, 1'b0, -1);
    endtask

    task automatic test_write_gap();
        logic [63:0] d [8];
        for (int k = 0; k < 8; k++) d[k] = 64'hA0 + 64'(k);
        do_write(64'h80, 13'h0000, d, 4, 2, -1);
        start_req(64'h80, 13'h1abc, 1'b0);
        finish_read(64'h2, 13'h1abc, -1, 0, 1'b0, -1);
    endtask

    task automatic test_resp_stall();
        start_req(64'h80, 13'h1005, 1'b0);
        finish_read(64'h2, 13'h1005, 2, 3, 1'b0, -1);
    endtask

    task automatic test_out_of_range();
        logic [63:0] d [8];
        logic [63:0] oor;
        oor = 64'(MEM_LINES) << 6;
        for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
        do_write(64'h0, 13'h0001, d, -1, 0, -1);
        start_req(oor, 13'h1111, 1'b0);
        finish_read(longint'(MEM_LINES), 13'h1111, -1, 0, 1'b0, -1);
        for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom} | 64'h1;
        do_write(oor, 13'h0002, d, -1, 0, -1);
        start_req(oor, 13'h1112, 1'b0);
        finish_read(longint'(MEM_LINES), 13'h1112, -1, 0, 1'b0, -1);
        start_req(64'h0, 13'h1113, 1'b0);
        finish_read(0, 13'h1113, -1, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        logic [63:0] d [8];
        start_req(64'h1040, 13'h1020, 1'b0);
        finish_read(64'h41, 13'h1020, -1, 0, 1'b0, 5);
        start_req(64'h1040, 13'h1021, 1'b0);
        finish_read(64'h41, 13'h1021, -1, 0, 1'b0, -1);
        for (int k = 0; k < 8; k++) d[k] = 64'hBEEF_0000 + 64'(k);
        do_write(64'h1040, 13'h0022, d, -1, 0, 3);
        start_req(64'h1040, 13'h1023, 1'b0);
        finish_read(64'h41, 13'h1023, -1, 0, 1'b0, -1);
    endtask

    task automatic test_reqcyc_held();
        start_req(64'h80, 13'h1030, 1'b1);
        finish_read(64'h2, 13'h1030, -1, 0, 1'b0, -1);
        @(negedge clk);
        n_checks++;
        if (bus.reqack !== 1'b1) begin
            n_fail++;
            $display("FAIL held_new_ack: reqack=%b required 1 one cycle after IDLE", bus.reqack);
        end
        bus.reqcyc = 1'b0;
        finish_read(64'h2, 13'h1030, -1, 0, 1'b0, -1);
        @(negedge clk);
        n_checks++;
        if (bus.reqack !== 1'b0 || bus.respcyc !== 1'b0) begin
            n_fail++;
            $display("FAIL held_single: reqack=%b respcyc=%b required 0 0", bus.reqack, bus.respcyc);
        end
    endtask

    task automatic test_random();
        logic [63:0] d [8];
        longint lines [$];
        longint ln;
        logic [TAG_W-1:0] tag;
        for (int i = 0; i < 16; i++) begin
            if (lines.size() == 0 || $urandom_range(0, 2) == 0) begin
                ln = longint'($urandom_range(0, MEM_LINES - 1));
                for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
                tag = {1'b0, 12'($urandom)};
                do_write((64'(ln) << 6) | 64'($urandom_range(0, 63)), tag, d,
                         int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), -1);
                lines.push_back(ln);
            end else begin
                ln  = lines[$urandom_range(0, lines.size() - 1)];
                tag = {1'b1, 12'($urandom)};
                start_req((64'(ln) << 6) | 64'($urandom_range(0, 63)), tag, 1'b0);
                finish_read(ln, tag, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, -1);
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        bus.reqcyc  = 1'b0;
        bus.req     = 64'd0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        test_reset();
        test_read_basic();
        test_write_gap();
        test_resp_stall();
        test_out_of_range();
        test_reset_mid();
        test_reqcyc_held();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from reqack pulse to first read beat (legal 1..15).
REQ-002 SHALL have parameter MEM_LINES, default 1024, meaning backing-store depth in 64-byte lines.
REQ-003 SHALL have parameter TAG_W, default 13, meaning tag width.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port reqcyc  in  1  initiator request/write-data valid.
REQ-007 SHALL have port req  in  64  request address on a request cycle; write data on a write-data cycle.
REQ-008 SHALL have port reqtag  in  TAG_W  request tag; bit TAG_W-1 = 1 for READ, 0 for WRITE.
REQ-009 SHALL have port reqack  out  1  one-cycle accept pulse for an address or a write-data beat.
REQ-010 SHALL have port respcyc  out  1  read-response beat valid.
REQ-011 SHALL have port resp  out  64  read-response data.
REQ-012 SHALL have port resptag  out  TAG_W  tag of the request being answered.
REQ-013 SHALL have port respack  in  1  initiator accepts the current beat.

Function
REQ-014 SHALL implement the FSM IDLE, ACK, WAIT, RESP, WDATA; reset state IDLE.
REQ-015 IDLE: reqcyc=1 latches line = req[63:6] and reqtag, moves to ACK; req[5:0] ignored.
REQ-016 ACK: reqack=1 for exactly that cycle; next state WAIT for READ, WDATA for WRITE.
REQ-017 WAIT: counter loaded with LATENCY-1 on entry, decrements each cycle; at 0 moves to RESP with beat index 0.
REQ-018 RESP: respcyc=1, resp = word[line*8 + beat], resptag = latched tag; resp and resptag held stable until respack=1.
REQ-019 RESP: respcyc&respack advances the beat; after beat 7 is accepted, respcyc drops the next cycle and the state returns to IDLE.
REQ-020 WDATA: each cycle with reqcyc=1 writes req into word[line*8 + beat], pulses reqack that cycle, increments the beat; after beat 7 returns to IDLE.
REQ-021 WDATA: cycles with reqcyc=0 SHALL stall without writing.
REQ-022 Beat index SHALL be 3 bits and wrap only at the end of a transfer; beats are in increasing address order from the line base.
REQ-023 A line >= MEM_LINES is out of range: reads return 64'h0 for all 8 beats; writes are acked and dropped.
REQ-024 reqcyc in any state other than IDLE/WDATA SHALL be ignored: no ack, no queueing.
REQ-025 Only one transaction SHALL be outstanding; a new request is sampled no earlier than the cycle after returning to IDLE.
REQ-026 Backing store is 64-bit words, not cleared by reset; initial contents are zero.
REQ-027 reqack and respcyc SHALL never both be 1 in the same cycle.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, reqack=0, respcyc=0, resp=0, resptag=0, beat=0, counter=0.
REQ-029 Reset mid-transfer SHALL abort it; write beats already accepted remain in memory; no further beats are produced.
REQ-030 After reset deasserts, the first rising edge with reqcyc=1 SHALL be treated as a new request.

Verification
REQ-031 Read, LATENCY=4, respack tied to respcyc, req=0x1040, tag=0x1000, memory line 0x41 words k = 0x100+k -> reqack pulse 1 cycle after request; first respcyc 4 cycles after the pulse; 8 consecutive beats 0x100..0x107, resptag=0x1000; then IDLE.
REQ-032 Write req=0x80, tag=0x0000, data 0xA0..0xA7 with reqcyc dropped for 2 cycles after beat 3, then read 0x80 -> 8 write acks with a 2-cycle gap; readback beats 0xA0..0xA7.
REQ-033 Read with respack held 0 for 3 cycles on beat 2 -> beat 2 data stable for 4 cycles; no beat skipped or duplicated; total 8 beats.
REQ-034 Read of req=MEM_LINES*64 (out of range) -> 8 beats of 0; write to same address -> 8 acks, memory unchanged.
REQ-035 reset=0 asserted between read beats 4 and 5 -> respcyc=0 at once; after release, a new read completes normally with 8 beats.
REQ-036 reqcyc held 1 throughout a read -> no second reqack until the cycle after returning to IDLE; then exactly one new transaction starts.
